// File: rtl/wbbus_master.sv
// rtl/wbbus_master.sv - Wishbone bus master: one single-beat read or write per core request
// Optional feature macro: WB_TIMEOUT_EN (bounded wait for ack_i, err_o flags expiry)
module wbbus_master #(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [WORD-1:0] addr_i,
    input  logic [WORD-1:0] wdata_i,
    output logic [WORD-1:0] rdata_o,
    output logic            done_o,
    output logic            err_o,
    output logic            busy_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [WORD-1:0] adr_o,
    output logic [WORD-1:0] dat_o,
    input  logic [WORD-1:0] dat_i,
    input  logic            ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            cyc_nxt, we_nxt, done_nxt, busy_nxt;
    logic [WORD-1:0] adr_nxt, dat_nxt, rdata_nxt;

    // A zero bound would expire before the first BUS cycle could ever be acked
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("wbbus_master: TIMEOUT must be at least 1");
    end

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_nxt;
    logic          expired;

    // Counter holds the number of BUS cycles already spent without ack, so the
    // TIMEOUT-th BUS cycle is the one where it equals TIMEOUT-1.
    assign expired = (cnt == CW'(TIMEOUT - 1));
`else
    assign err_o = 1'b0;
`endif

    // Strobe and cycle always move together for single-beat transfers
    assign stb_o = cyc_o;

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_o;
        we_nxt    = we_o;
        adr_nxt   = adr_o;
        dat_nxt   = dat_o;
        rdata_nxt = rdata_o;
        busy_nxt  = busy_o;
        done_nxt  = 1'b0;
`ifdef WB_TIMEOUT_EN
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_i) begin
                    adr_nxt   = addr_i;
                    dat_nxt   = wdata_i;
                    we_nxt    = we_i;
                    cyc_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = BUS;
`ifdef WB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            BUS: begin
                if (ack_i) begin
                    cyc_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                    if (!we_o) begin
                        rdata_nxt = dat_i;
                    end
                end
`ifdef WB_TIMEOUT_EN
                else if (expired) begin
                    cyc_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                cyc_nxt   = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any request or ack
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cyc_o   <= 1'b0;
            we_o    <= 1'b0;
            adr_o   <= '0;
            dat_o   <= '0;
            rdata_o <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt     <= '0;
            err_o   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cyc_o   <= cyc_nxt;
            we_o    <= we_nxt;
            adr_o   <= adr_nxt;
            dat_o   <= dat_nxt;
            rdata_o <= rdata_nxt;
            done_o  <= done_nxt;
            busy_o  <= busy_nxt;
`ifdef WB_TIMEOUT_EN
            cnt     <= cnt_nxt;
            err_o   <= err_nxt;
`endif
        end
    end

endmodule
